// File: rtl/lfsr_check_pkg.sv
// Shared types and constants for the LFSR period checker.
// State enum, error codes and default parameter values.
package lfsr_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    RUN,
    DONE
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_LOCKUP  = 2'd2;
  localparam logic [1:0] ERR_INVALID = 2'd3;

  localparam int DEF_MAX_LENGTH = 15;
  localparam int DEF_CNT_W      = 16;
  localparam int VAL_W          = 16;

endpackage

// File: rtl/lfsr_expected_period.sv
// Combinational reference values for register length L.
// Ports: length in; mask, full (2^L-1), bound (2^L), half (2^(L-1)) out.
module lfsr_expected_period
  import lfsr_check_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic [4:0]       length,
  output logic [VAL_W-1:0] mask,
  output logic [CNT_W-1:0] full,
  output logic [CNT_W-1:0] bound,
  output logic [CNT_W-1:0] half
);

  // Wide enough that any 5-bit length shifts without loss;
  // out-of-range lengths give junk that is never used.
  logic [32:0] pow;

  assign pow   = 33'd1 << length;
  assign mask  = VAL_W'(pow - 33'd1);
  assign full  = CNT_W'(pow - 33'd1);
  assign bound = CNT_W'(pow);
  assign half  = CNT_W'(pow >> 1);

endmodule

// File: rtl/lfsr_period_checker.sv
// Measures an LFSR's period from a seed sample and checks it is maximal.
// Ports: clk, rst (sync, active-high), start, lfsr_length, sample_en,
//   lfsr_value, lfsr_valid in; busy, done, pass, err, period,
//   ones_count out (all registered).
// Macro LFSR_PERIOD_CHECKER_ONES_EN adds the bit-0 ones counter and
// makes pass also require ones_count = 2^(L-1).
module lfsr_period_checker
  import lfsr_check_pkg::*;
#(
  parameter int MAX_LENGTH = DEF_MAX_LENGTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       lfsr_length,
  input  logic             sample_en,
  input  logic [15:0]      lfsr_value,
  input  logic             lfsr_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] ones_count
);

  state_t           state_q, state_n;
  logic [VAL_W-1:0] mask_q, mask_n;
  logic [CNT_W-1:0] full_q, full_n;
  logic [CNT_W-1:0] bound_q, bound_n;
  logic [VAL_W-1:0] seed_q, seed_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic [CNT_W-1:0] period_q, period_n;
  logic             pass_q, pass_n;
  logic [1:0]       err_q, err_n;
  logic             done_q, done_n;
  logic             busy_q, busy_n;

  logic [VAL_W-1:0] exp_mask;
  logic [CNT_W-1:0] exp_full;
  logic [CNT_W-1:0] exp_bound;
  logic [CNT_W-1:0] exp_half;

  logic [VAL_W-1:0] masked;
  logic [CNT_W-1:0] c;
  logic             bad_len;
  logic             ones_ok;

`ifdef LFSR_PERIOD_CHECKER_ONES_EN
  logic [CNT_W-1:0] half_q, half_n;
  logic [CNT_W-1:0] ones_q, ones_n;
`else
  logic             unused_half;
  assign unused_half = ^exp_half;
`endif

  lfsr_expected_period #(
    .CNT_W(CNT_W)
  ) u_exp (
    .length(lfsr_length),
    .mask  (exp_mask),
    .full  (exp_full),
    .bound (exp_bound),
    .half  (exp_half)
  );

  assign masked  = lfsr_value & mask_q;
  assign c       = count_q + CNT_W'(1);
  assign bad_len = (lfsr_length < 5'd2) ||
                   (int'(lfsr_length) > MAX_LENGTH);

  // The terminating sample is not counted: the seed sample
  // already covered that point of the cycle.
`ifdef LFSR_PERIOD_CHECKER_ONES_EN
  assign ones_ok = (ones_q == half_q);
`else
  assign ones_ok = 1'b1;
`endif

  always_comb begin
    state_n  = state_q;
    mask_n   = mask_q;
    full_n   = full_q;
    bound_n  = bound_q;
    seed_n   = seed_q;
    count_n  = count_q;
    period_n = period_q;
    pass_n   = pass_q;
    err_n    = err_q;
`ifdef LFSR_PERIOD_CHECKER_ONES_EN
    half_n   = half_q;
    ones_n   = ones_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mask_n   = exp_mask;
          full_n   = exp_full;
          bound_n  = exp_bound;
          period_n = '0;
          pass_n   = 1'b0;
          err_n    = ERR_NONE;
`ifdef LFSR_PERIOD_CHECKER_ONES_EN
          half_n   = exp_half;
          ones_n   = '0;
`endif
          if (bad_len) begin
            err_n   = ERR_INVALID;
            state_n = DONE;
          end else begin
            state_n = SEED;
          end
        end
      end
      SEED: begin
        if (sample_en) begin
          if (!lfsr_valid) begin
            err_n   = ERR_INVALID;
            state_n = DONE;
          end else if (masked == '0) begin
            err_n   = ERR_LOCKUP;
            state_n = DONE;
          end else begin
            seed_n  = masked;
            count_n = '0;
`ifdef LFSR_PERIOD_CHECKER_ONES_EN
            ones_n  = CNT_W'(lfsr_value[0]);
`endif
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (sample_en) begin
          if (!lfsr_valid) begin
            err_n   = ERR_INVALID;
            state_n = DONE;
          end else if (masked == seed_q) begin
            period_n = c;
            pass_n   = (c == full_q) && ones_ok;
            state_n  = DONE;
          end else if (masked == '0) begin
            period_n = c;
            err_n    = ERR_LOCKUP;
            state_n  = DONE;
          end else if (c == bound_q) begin
            period_n = c;
            err_n    = ERR_TIMEOUT;
            state_n  = DONE;
          end else begin
            count_n = c;
`ifdef LFSR_PERIOD_CHECKER_ONES_EN
            ones_n  = ones_q + CNT_W'(lfsr_value[0]);
`endif
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // Flags follow the next state so they line up with it.
    done_n = (state_n == DONE);
    busy_n = (state_n == SEED) || (state_n == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      full_q   <= '0;
      bound_q  <= '0;
      seed_q   <= '0;
      count_q  <= '0;
      period_q <= '0;
      pass_q   <= 1'b0;
      err_q    <= ERR_NONE;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef LFSR_PERIOD_CHECKER_ONES_EN
      half_q   <= '0;
      ones_q   <= '0;
`endif
    end else begin
      state_q  <= state_n;
      mask_q   <= mask_n;
      full_q   <= full_n;
      bound_q  <= bound_n;
      seed_q   <= seed_n;
      count_q  <= count_n;
      period_q <= period_n;
      pass_q   <= pass_n;
      err_q    <= err_n;
      done_q   <= done_n;
      busy_q   <= busy_n;
`ifdef LFSR_PERIOD_CHECKER_ONES_EN
      half_q   <= half_n;
      ones_q   <= ones_n;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign pass   = pass_q;
  assign err    = err_q;
  assign period = period_q;
`ifdef LFSR_PERIOD_CHECKER_ONES_EN
  assign ones_count = ones_q;
`else
  assign ones_count = '0;
`endif

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Directed bench for lfsr_period_checker with a result scoreboard.
// Honours LFSR_PERIOD_CHECKER_ONES_EN for the ones_count expectations.
module tb_lfsr_period_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  lfsr_length;
  logic        sample_en;
  logic [15:0] lfsr_value;
  logic        lfsr_valid;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  err;
  logic [15:0] period;
  logic [15:0] ones_count;

  lfsr_period_checker dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .lfsr_length(lfsr_length),
    .sample_en  (sample_en),
    .lfsr_value (lfsr_value),
    .lfsr_valid (lfsr_valid),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err        (err),
    .period     (period),
    .ones_count (ones_count)
  );

  always #5 clk = ~clk;

`ifdef LFSR_PERIOD_CHECKER_ONES_EN
  localparam bit ONES = 1'b1;
`else
  localparam bit ONES = 1'b0;
`endif

  typedef struct {
    logic [1:0]  err;
    logic [15:0] period;
    logic        pass;
    logic [15:0] ones;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] e, input logic [15:0] p,
                      input logic ps, input logic [15:0] o);
    exp_t x;
    x.err    = e;
    x.period = p;
    x.pass   = ps;
    x.ones   = ONES ? o : 16'd0;
    sb.push_back(x);
  endtask

  task automatic do_start(input logic [4:0] len);
    start       = 1'b1;
    lfsr_length = len;
    tick();
    start       = 1'b0;
    lfsr_length = 5'd9;
  endtask

  // kind 0: 4-bit LFSR x^4+x^3+1 from 1; 1: valid low;
  // 2: counter 1 then 2..31 wrapping; 3: 5 then 0.
  task automatic run_seq(input int kind, input int budget,
                         input int inj, output int n);
    logic [3:0]  s;
    logic [15:0] junk;
    s = 4'd1;
    n = 0;
    while (!done && n < budget) begin
      junk       = 16'((n + 3) << 8);
      sample_en  = 1'b1;
      lfsr_valid = 1'b1;
      start      = (n == inj);
      lfsr_length = (n == inj) ? 5'd1 : 5'd9;
      case (kind)
        0: lfsr_value = junk | 16'(s);
        1: begin
          lfsr_value = junk | 16'h00ff;
          lfsr_valid = 1'b0;
        end
        2: lfsr_value = junk |
             ((n == 0) ? 16'd1 : 16'(((n - 1) % 30) + 2));
        default: lfsr_value = junk | ((n == 0) ? 16'd5 : 16'd0);
      endcase
      s = {s[2:0], s[3] ^ s[2]};
      tick();
      n++;
    end
    sample_en  = 1'b0;
    start      = 1'b0;
    lfsr_valid = 1'b1;
  endtask

  task automatic check_result(input string tag, input int n,
                              input int n_exp);
    exp_t e;
    chk({tag, "_samples"}, 32'(n), 32'(n_exp));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_err"}, 32'(err), 32'(e.err));
      chk({tag, "_period"}, 32'(period), 32'(e.period));
      chk({tag, "_pass"}, 32'(pass), 32'(e.pass));
      chk({tag, "_ones"}, 32'(ones_count), 32'(e.ones));
      tick();
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_pass_held"}, 32'(pass), 32'(e.pass));
      chk({tag, "_err_held"}, 32'(err), 32'(e.err));
    end
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    start       = 1'b0;
    lfsr_length = 5'd0;
    sample_en   = 1'b0;
    lfsr_value  = 16'd0;
    lfsr_valid  = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_ones", 32'(ones_count), 32'd0);
    rst = 1'b0;
    tick();

    // Maximal 4-bit LFSR
    do_start(5'd4);
    chk("l4_busy_n1", 32'(busy), 32'd1);
    push(2'd0, 16'd15, 1'b1, 16'd8);
    run_seq(0, 40, -1, n);
    check_result("l4", n, 16);

    // LFSR reports invalid on its first step
    do_start(5'd8);
    push(2'd3, 16'd0, 1'b0, 16'd0);
    run_seq(1, 10, -1, n);
    check_result("l8_invalid", n, 1);

    // Counter never returns to the seed
    do_start(5'd5);
    push(2'd1, 16'd32, 1'b0, 16'd16);
    run_seq(2, 60, -1, n);
    check_result("l5_timeout", n, 33);

    // Second sample is all zero
    do_start(5'd6);
    push(2'd2, 16'd1, 1'b0, 16'd1);
    run_seq(3, 10, -1, n);
    check_result("l6_lockup", n, 2);

    // Reset mid-measurement, then a clean rerun
    do_start(5'd4);
    run_seq(0, 7, -1, n);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_pass", 32'(pass), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_period", 32'(period), 32'd0);
    chk("abort_ones", 32'(ones_count), 32'd0);
    tick();
    chk("abort_no_done", 32'(done), 32'd0);
    do_start(5'd4);
    push(2'd0, 16'd15, 1'b1, 16'd8);
    run_seq(0, 40, -1, n);
    check_result("rerun", n, 16);

    // Bad lengths finish at N+1 without busy
    do_start(5'd1);
    push(2'd3, 16'd0, 1'b0, 16'd0);
    check_result("len1", 0, 0);
    chk("len1_busy_after", 32'(busy), 32'd0);
    do_start(5'd16);
    push(2'd3, 16'd0, 1'b0, 16'd0);
    // start presented during the DONE cycle must be ignored
    start       = 1'b1;
    lfsr_length = 5'd4;
    check_result("len16", 0, 0);
    start = 1'b0;
    chk("done_start_ignored", 32'(busy), 32'd0);
    tick();
    chk("done_start_idle", 32'(busy), 32'd0);

    // start with a bad length during RUN is ignored
    do_start(5'd4);
    push(2'd0, 16'd15, 1'b1, 16'd8);
    run_seq(0, 40, 5, n);
    check_result("run_start", n, 16);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_period_checker.md
# lfsr_period_checker

Downstream self-test stage for the Fibonacci LFSR. It samples the LFSR value/valid outputs on a per-step strobe and latches the first sample as a seed. It then counts steps until the low `length` bits of the value return to that seed, and reports the measured period with pass/fail against the maximal-length period 2^L−1. It sits between the LFSR core and the top-level output mux, giving the top a self-checked result instead of raw value bits.

## Interface
- `MAX_LENGTH`, 15: largest supported register length L. Lengths 2..MAX_LENGTH are accepted.
- `CNT_W`, 16: width of the period and ones counters. Must satisfy 2^MAX_LENGTH ≤ 2^CNT_W − 1.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a measurement. Honoured only in IDLE.
- `lfsr_length` in 5: register length L. Latched when `start` is accepted.
- `sample_en` in 1: one-cycle strobe marking a new LFSR step on `lfsr_value`/`lfsr_valid`.
- `lfsr_value` in 16: LFSR state. Only bits [L−1:0] are compared.
- `lfsr_valid` in 1: LFSR valid flag.
- `busy` out 1: high in SEED and RUN.
- `done` out 1: one-cycle pulse when a result is final.
- `pass` out 1: result is good. Held until the next accepted `start`.
- `err` out 2: error code. 0 none, 1 timeout, 2 lockup, 3 invalid (bad length or `lfsr_valid` low). Held like `pass`.
- `period` out CNT_W: measured period. Held like `pass`.
- `ones_count` out CNT_W: number of 1s on bit 0 over one period. Tied to 0 unless the macro is defined.

## Operation
- States: IDLE, SEED, RUN, DONE.
- IDLE, `start`=1:
  - Latch L, clear `period`, `ones_count`, `pass`, `err`.
  - If L<2 or L>MAX_LENGTH: set err=3, go to DONE.
  - Otherwise go to SEED.
- A "sample" is any cycle with `sample_en`=1.
- SEED, sample with `lfsr_valid`=1:
  - masked value = 0: set err=2, go to DONE.
  - Otherwise: seed ← masked value, count ← 0, ones ← `lfsr_value[0]`, go to RUN.
- SEED or RUN, sample with `lfsr_valid`=0: set err=3, go to DONE.
- RUN, sample with `lfsr_valid`=1, with c = count+1:
  - masked = seed: `period`←c, go to DONE.
  - else masked = 0: `period`←c, err=2, go to DONE.
  - else c = 2^L: `period`←c, err=1, go to DONE.
  - else: count←c, ones += `lfsr_value[0]`.
- DONE: assert `done` for exactly one cycle.
  - `pass` = (err=0) and (`period` = 2^L−1), plus the ones condition under the macro.
  - Next state is IDLE.
- Cycles without `sample_en` hold all state.
- `start` outside IDLE is ignored. `lfsr_length` changes after acceptance are ignored.
- Counter arithmetic is unsigned CNT_W. The 2^L bound guarantees no wrap.

## Timing
- Reset: state IDLE. `busy`, `done`, `pass`, `err`, `period`, `ones_count` are all 0. Internal seed and count are 0.
- `rst` mid-measurement aborts to IDLE with the reset values above. No `done` pulse.
- `start` accepted at cycle N: `busy`=1 from cycle N+1.
- Bad length: `done`=1 at cycle N+1, `busy` stays 0.
- Terminating sample at cycle M: `done`, `pass`, `err`, `period` are valid at cycle M+1. `busy`=0 from M+1.
- A `start` in the DONE cycle is ignored. The earliest restart is in the IDLE cycle that follows.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `LFSR_PERIOD_CHECKER_ONES_EN`.
- Defined:
  - ones counter is built and `ones_count` reports it.
  - `pass` additionally requires `ones_count` = 2^(L−1).
- Undefined:
  - no ones counter logic, `ones_count` is constant 0.
  - `pass` depends only on `err` and `period`.

## Structure
- Package `lfsr_check_pkg`:
  - state enum (IDLE, SEED, RUN, DONE)
  - err code constants ERR_NONE, ERR_TIMEOUT, ERR_LOCKUP, ERR_INVALID
  - default MAX_LENGTH and CNT_W
- Sub-module `lfsr_expected_period`: combinational. From L it produces the length mask, 2^L−1, 2^L and 2^(L−1). Its outputs are registered at `start` acceptance.

## Test plan
- L=4, real 2-tap LFSR seeded 0x0001, `sample_en` every cycle → `done` after 15 RUN samples, period=15, err=0, pass=1, ones_count=8 with macro.
- L=8, 2-tap mode (LFSR outputs `lfsr_valid`=0) → err=3, pass=0, `done` one cycle after the first sample.
- L=5, value driven from a binary up-counter → no seed match, period=32, err=1, pass=0.
- L=6, second sample masked value 0 → err=2, period=1, pass=0.
- L=4, `rst` asserted after 7 samples → next cycle IDLE with all outputs 0. A new `start` then completes normally with period=15.
- `start` with L=1, then L=16 → err=3, `done` at N+1, `busy` never high. A `start` during RUN leaves the current result unaffected.
